trigger_manager_multi: RTL and testbench

Parametrised multi-channel trigger manager for the master FPGA. It accepts a front-panel trigger, issues per-channel `go` to a configurable, maskable set of channels, and waits for their `done` flags under an optional timeout. It then writes one fill record (trigger number, type, timeout mask) to the fill FIFO over a valid/ready handshake, and holds channel trigger-arm low until the FIFO and channel manager are free again. It replaces the fixed five-channel manager wherever channel count or trigger-number width differs, or where a hung channel must not stall acquisition.

---
 rtl/trigger_manager_multi.sv | 150 +++++++++++++++
 tb/tb_trigger_manager_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_manager_multi.sv
// Multi-channel trigger manager: accepts a trigger, starts a masked set of channels,
// waits for their done flags (with an optional timeout), then emits one fill record.
module trigger_manager_multi #(
  parameter int NCHAN      = 5,
  parameter int TRIG_NUM_W = 24,
  parameter int TIMEOUT_W  = 16,
  parameter int DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [1:0]            trig_type,
  input  logic [NCHAN-1:0]      chan_en,
  input  logic [TIMEOUT_W-1:0]  timeout_cycles,
  input  logic [NCHAN-1:0]      done,
  input  logic                  cm_busy,
  input  logic                  fifo_filled,
  input  logic                  fifo_ready,
  output logic [NCHAN-1:0]      go,
  output logic [NCHAN-1:0]      trig_arm,
  output logic [TRIG_NUM_W-1:0] trig_num,
  output logic                  fifo_valid,
  output logic [1:0]            fifo_type,
  output logic [NCHAN-1:0]      fifo_timeout_mask,
  output logic [DROP_W-1:0]     drop_count,
  output logic                  timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_FILL     = 4'b0010,
    S_STORE    = 4'b0100,
    S_ARM_WAIT = 4'b1000
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_ONE = TIMEOUT_W'(1);

  state_t                  r_state;
  logic [NCHAN-1:0]        r_mask;
  logic [1:0]              r_type;
  logic [TRIG_NUM_W-1:0]   r_trig_num;
  logic [TIMEOUT_W-1:0]    r_timer;
  logic [DROP_W-1:0]       r_drop;
  logic [NCHAN-1:0]        r_go;
  logic [NCHAN-1:0]        r_arm;
  logic                    r_valid;
  logic [NCHAN-1:0]        r_tmask;
  logic                    r_terr;

  state_t                  w_state_next;
  logic                    w_accept;
  logic                    w_all_done;
  logic                    w_timeout_hit;
  logic                    w_timed_out;
  logic [NCHAN-1:0]        w_mask_next;
  logic [NCHAN-1:0]        w_go_next;
  logic [NCHAN-1:0]        w_arm_next;
  logic                    w_valid_next;
  logic [NCHAN-1:0]        w_tmask_next;

  assign w_accept      = (r_state == S_IDLE) && trigger && !cm_busy && (|chan_en);
  // Disabled channels count as done so they never hold up a fill.
  assign w_all_done    = &(done | ~r_mask);
  assign w_timeout_hit = (timeout_cycles != '0) && (r_timer == timeout_cycles - TIMER_ONE);

  always_comb begin
    w_state_next = r_state;
    w_timed_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_FILL;
      end
      S_FILL: begin
        if (w_all_done) begin
          w_state_next = S_STORE;
        end else if (w_timeout_hit) begin
          w_state_next = S_STORE;
          w_timed_out  = 1'b1;
        end
      end
      S_STORE: begin
        if (fifo_ready) w_state_next = S_ARM_WAIT;
      end
      S_ARM_WAIT: begin
        if (!fifo_filled && !cm_busy) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they move on the same edge as the state.
  always_comb begin
    w_mask_next  = w_accept ? chan_en : r_mask;
    w_go_next    = (w_state_next == S_FILL) ? w_mask_next : '0;
    w_arm_next   = ((w_state_next == S_IDLE) || (w_state_next == S_FILL)) ? '1 : '0;
    w_valid_next = (w_state_next == S_STORE);
    w_tmask_next = r_tmask;
    if ((r_state == S_FILL) && w_all_done) begin
      w_tmask_next = '0;
    end else if (w_timed_out) begin
      w_tmask_next = r_mask & ~done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_type     <= '0;
      r_trig_num <= '0;
      r_timer    <= '0;
      r_drop     <= '0;
      r_go       <= '0;
      r_arm      <= '1;
      r_valid    <= 1'b0;
      r_tmask    <= '0;
      r_terr     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_go    <= w_go_next;
      r_arm   <= w_arm_next;
      r_valid <= w_valid_next;
      r_tmask <= w_tmask_next;
      if (w_accept) begin
        r_type     <= trig_type;
        r_trig_num <= r_trig_num + 1'b1;
        r_timer    <= '0;
      end else if (r_state == S_FILL) begin
        r_timer <= r_timer + 1'b1;
      end
      if (trigger && !w_accept && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
      if (w_timed_out) begin
        r_terr <= 1'b1;
      end
    end
  end

  assign go                = r_go;
  assign trig_arm          = r_arm;
  assign trig_num          = r_trig_num;
  assign fifo_valid        = r_valid;
  assign fifo_type         = r_type;
  assign fifo_timeout_mask = r_tmask;
  assign drop_count        = r_drop;
  assign timeout_err       = r_terr;

endmodule

// File: tb/tb_trigger_manager_multi.sv
// Randomized bench for trigger_manager_multi: a transaction-level reference model feeds a
// record scoreboard and per-cycle output expectations for a default and a narrow instance.
module tb_trigger_manager_multi;

  logic        clk = 1'b0;
  logic        reset, trigger, cm_busy, fifo_filled, fifo_ready;
  logic [1:0]  trig_type;
  logic [4:0]  chan_en, done;
  logic [15:0] timeout_cycles;

  logic [4:0]  dut_go, dut_arm, dut_tmask;
  logic [23:0] dut_num;
  logic        dut_valid, dut_terr;
  logic [1:0]  dut_type;
  logic [15:0] dut_drop;

  logic [4:0]  sm_go, sm_arm, sm_tmask;
  logic [3:0]  sm_num;
  logic        sm_valid, sm_terr;
  logic [1:0]  sm_type;
  logic [1:0]  sm_drop;

  always #5 clk = ~clk;

  trigger_manager_multi u_dut (
    .clk(clk), .reset(reset), .trigger(trigger), .trig_type(trig_type), .chan_en(chan_en),
    .timeout_cycles(timeout_cycles), .done(done), .cm_busy(cm_busy), .fifo_filled(fifo_filled),
    .fifo_ready(fifo_ready), .go(dut_go), .trig_arm(dut_arm), .trig_num(dut_num),
    .fifo_valid(dut_valid), .fifo_type(dut_type), .fifo_timeout_mask(dut_tmask),
    .drop_count(dut_drop), .timeout_err(dut_terr)
  );

  trigger_manager_multi #(.NCHAN(5), .TRIG_NUM_W(4), .TIMEOUT_W(16), .DROP_W(2)) u_small (
    .clk(clk), .reset(reset), .trigger(trigger), .trig_type(trig_type), .chan_en(chan_en),
    .timeout_cycles(timeout_cycles), .done(done), .cm_busy(cm_busy), .fifo_filled(fifo_filled),
    .fifo_ready(fifo_ready), .go(sm_go), .trig_arm(sm_arm), .trig_num(sm_num),
    .fifo_valid(sm_valid), .fifo_type(sm_type), .fifo_timeout_mask(sm_tmask),
    .drop_count(sm_drop), .timeout_err(sm_terr)
  );

  typedef struct {
    int unsigned num;
    logic [1:0]  typ;
    logic [4:0]  tmask;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          go_cnt, arm_low_cnt, rec_cnt;

  // Reference model: phase 0 idle, 1 filling, 2 record offered, 3 waiting to re-arm.
  int          m_phase = 0;
  int unsigned m_accepts = 0;
  int unsigned m_drops = 0;
  int          m_age = 0;
  logic [4:0]  m_mask = '0;
  logic [4:0]  m_tmask = '0;
  logic [1:0]  m_type = '0;
  bit          m_terr = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  task automatic model_step();
    logic       acc;
    logic [4:0] missing;
    if (reset) begin
      m_phase = 0; m_accepts = 0; m_drops = 0; m_type = '0;
      m_tmask = '0; m_terr = 1'b0; m_mask = '0;
      exp_q.delete();
      return;
    end
    acc = (m_phase == 0) && trigger && !cm_busy && (chan_en != 5'd0);
    if (trigger && !acc) m_drops++;
    case (m_phase)
      0: if (acc) begin
        m_accepts++; m_mask = chan_en; m_type = trig_type; m_age = 0; m_phase = 1;
      end
      1: begin
        missing = m_mask & ~done;
        if (missing == 5'd0) begin
          m_tmask = '0;
          exp_q.push_back('{m_accepts, m_type, m_tmask});
          m_phase = 2;
        end else if (timeout_cycles != 16'd0 && m_age == int'(timeout_cycles) - 1) begin
          m_tmask = missing; m_terr = 1'b1;
          exp_q.push_back('{m_accepts, m_type, m_tmask});
          m_phase = 2;
        end else begin
          m_age++;
        end
      end
      2: if (fifo_ready) m_phase = 3;
      3: if (!fifo_filled && !cm_busy) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; trigger = 1'b0; done = '0; cm_busy = 1'b0;
    fifo_filled = 1'b0; fifo_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  // Monitor: per-cycle output expectations and record scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("go", dut_go, (m_phase == 1) ? m_mask : 5'd0);
        chk("trig_arm", dut_arm, (m_phase <= 1) ? 5'h1f : 5'h00);
        chk("fifo_valid", dut_valid, m_phase == 2);
        chk("trig_num", dut_num, m_accepts & 32'hff_ffff);
        chk("drop_count", dut_drop, (m_drops > 65535) ? 65535 : m_drops);
        chk("timeout_err", dut_terr, m_terr);
        chk("fifo_type", dut_type, m_type);
        chk("fifo_timeout_mask", dut_tmask, m_tmask);
        chk("small_trig_num", sm_num, m_accepts & 32'hf);
        chk("small_drop_count", sm_drop, (m_drops > 3) ? 3 : m_drops);
        chk("small_fifo_valid", sm_valid, m_phase == 2);
        if (dut_go != 5'd0) go_cnt++;
        if (dut_arm == 5'd0) arm_low_cnt++;
        if (dut_valid) begin
          if (exp_q.size() == 0) begin
            chk("record_unexpected", 1, 0);
          end else begin
            chk("rec_trig_num", dut_num, exp_q[0].num & 32'hff_ffff);
            chk("rec_type", dut_type, exp_q[0].typ);
            chk("rec_timeout_mask", dut_tmask, exp_q[0].tmask);
            if (fifo_ready && !reset) begin
              void'(exp_q.pop_front());
              rec_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    idle_inputs();
    reset = 1'b1; trig_type = '0; chan_en = '0; timeout_cycles = '0;
    tick(); tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Full mask, done three cycles after the trigger.
    go_cnt = 0; arm_low_cnt = 0; rec_cnt = 0;
    chan_en = 5'h1f; trig_type = 2'd1; trigger = 1'b1; tick();
    trigger = 1'b0; tick(); tick();
    done = 5'h1f; tick();
    done = 5'h00; repeat (6) tick();
    chk("basic_go_cycles", go_cnt, 3);
    chk("basic_arm_low_cycles", arm_low_cnt, 2);
    chk("basic_records", rec_cnt, 1);
    chk("basic_trig_num", dut_num, 1);

    // Partial mask: disabled channels never asserting done must not matter.
    go_cnt = 0; rec_cnt = 0;
    chan_en = 5'b00101; done = 5'b00101; trig_type = 2'd2; trigger = 1'b1; tick();
    trigger = 1'b0; repeat (8) tick();
    chk("partial_go_cycles", go_cnt, 1);
    chk("partial_records", rec_cnt, 1);

    // Timeout with channel 3 hung.
    go_cnt = 0; rec_cnt = 0;
    timeout_cycles = 16'd10; chan_en = 5'h1f; done = 5'b10111; trig_type = 2'd3;
    trigger = 1'b1; tick();
    trigger = 1'b0; repeat (16) tick();
    chk("timeout_go_cycles", go_cnt, 10);
    chk("timeout_mask", dut_tmask, 5'b01000);
    chk("timeout_err_set", dut_terr, 1);
    done = 5'h00; timeout_cycles = 16'd0; repeat (3) tick();
    chk("timeout_err_sticky", dut_terr, 1);

    // Back-pressure in STORE and triggers dropped during a fill.
    do_reset();
    rec_cnt = 0;
    chan_en = 5'h1f; trig_type = 2'd2; trigger = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1; tick();
      trigger = 1'b0; tick();
    end
    chk("drops_three", dut_drop, 3);
    for (int i = 0; i < 2; i++) begin
      trigger = 1'b1; tick();
      trigger = 1'b0; tick();
    end
    chk("drops_five", dut_drop, 5);
    chk("small_drops_saturated", sm_drop, 3);
    done = 5'h1f; fifo_ready = 1'b0; tick();
    done = 5'h00; repeat (5) tick();
    chk("stall_valid_held", dut_valid, 1);
    fifo_ready = 1'b1; repeat (4) tick();
    chk("stall_records", rec_cnt, 1);

    // Trigger-number wrap on the 4-bit instance.
    do_reset();
    chan_en = 5'h1f; done = 5'h1f; trigger = 1'b1;
    guard = 0;
    while (m_accepts < 16 && guard < 200) begin
      tick();
      guard++;
    end
    chk("wrap_within_budget", guard < 200, 1);
    chk("wrap_small_trig_num", sm_num, 0);
    chk("wrap_trig_num", dut_num, 16);
    idle_inputs(); repeat (5) tick();

    // Reset in the middle of a fill.
    chan_en = 5'h1f; trigger = 1'b1; tick();
    trigger = 1'b0; tick(); tick();
    reset = 1'b1; tick();
    chk("rst_go", dut_go, 0);
    chk("rst_trig_arm", dut_arm, 5'h1f);
    chk("rst_trig_num", dut_num, 0);
    chk("rst_fifo_valid", dut_valid, 0);
    reset = 1'b0; repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 799) == 0);
      trigger     = ($urandom_range(0, 3) == 0);
      trig_type   = 2'($urandom);
      chan_en     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      for (int b = 0; b < 5; b++) done[b] = ($urandom_range(0, 9) < 7);
      cm_busy     = ($urandom_range(0, 5) == 0);
      fifo_filled = ($urandom_range(0, 4) == 0);
      fifo_ready  = ($urandom_range(0, 2) != 0);
      if (m_phase == 0 && $urandom_range(0, 19) == 0) timeout_cycles = 16'($urandom_range(0, 12));
      tick();
    end

    idle_inputs(); done = 5'h1f; trigger = 1'b0;
    repeat (12) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
